// File: rtl/bird_physics_controller_if.sv
// rtl/bird_physics_controller_if.sv - frame tick / flap inputs and game-state outputs of the bird engine
interface bird_physics_controller_if;
  logic        iFrameTick;
  logic        iFlap;
  logic [9:0]  oBirdY;
  logic [15:0] oScore;
  logic [1:0]  oState;
  logic        oGameOver;

  modport master (
    output iFrameTick,
    output iFlap,
    input  oBirdY,
    input  oScore,
    input  oState,
    input  oGameOver
  );

  modport slave (
    input  iFrameTick,
    input  iFlap,
    output oBirdY,
    output oScore,
    output oState,
    output oGameOver
  );
endinterface

// File: rtl/bird_physics_controller.sv
// rtl/bird_physics_controller.sv - per-frame bird physics, score and READY/PLAYING/DEAD engine (option: BIRD_CEILING_KILL_EN)
module bird_physics_controller #(
  parameter int SCREEN_HEIGHT     = 480,
  parameter int BIRD_HEIGHT       = 24,
  parameter int START_Y           = 228,
  parameter int GRAVITY           = 4,
  parameter int FLAP_VELOCITY     = 96,
  parameter int MAX_FALL_VELOCITY = 128,
  parameter int SCORE_FRAMES      = 60,
  parameter int DEAD_HOLD_FRAMES  = 30
) (
  input logic                     iClock,
  input logic                     iResetN,
  bird_physics_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_READY   = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DEAD    = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

`ifdef BIRD_CEILING_KILL_EN
  localparam bit CEIL_KILL = 1'b1;
`else
  localparam bit CEIL_KILL = 1'b0;
`endif

  // All physics math is 16-bit signed; positions are 10.4 fixed point.
  localparam logic signed [15:0] GRAV_S    = 16'(GRAVITY);
  localparam logic signed [15:0] FLAP_S    = 16'(FLAP_VELOCITY);
  localparam logic signed [15:0] MAXF_S    = 16'(MAX_FALL_VELOCITY);
  localparam logic signed [15:0] FLOOR_S   = 16'((SCREEN_HEIGHT - BIRD_HEIGHT) * 16);
  localparam logic [13:0]        FLOOR_FP  = 14'((SCREEN_HEIGHT - BIRD_HEIGHT) * 16);
  localparam logic [13:0]        START_FP  = 14'(START_Y * 16);
  localparam logic [15:0]        SCORE_LAST = 16'(SCORE_FRAMES - 1);
  localparam logic [15:0]        HOLD_DONE  = 16'(DEAD_HOLD_FRAMES);

  state_t             state;
  logic               game_over;
  logic [13:0]        pos;
  logic signed [11:0] vel;
  logic [15:0]        score;
  logic [15:0]        frame_cnt;
  logic [15:0]        hold_cnt;

  logic flap_s1, flap_s2, flap_d, flap_pending;
  logic flap_edge;

  logic signed [15:0] vel_ext, vel_grav, vel_n, pos_n;
  logic               hit_floor, hit_ceil, do_play;

  assign flap_edge = flap_s2 & ~flap_d;

  // Synchronise the button, detect its rising edge, and latch one flap per frame.
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      flap_s1      <= 1'b0;
      flap_s2      <= 1'b0;
      flap_d       <= 1'b0;
      flap_pending <= 1'b0;
    end else begin
      flap_s1 <= bus.iFlap;
      flap_s2 <= flap_s1;
      flap_d  <= flap_s2;
      // The tick consumes the pending flap; an edge landing on the tick carries to the next frame.
      if (bus.iFrameTick) begin
        flap_pending <= flap_edge;
      end else if (flap_edge) begin
        flap_pending <= 1'b1;
      end
    end
  end

  // Candidate velocity/position for a PLAYING update and its floor/ceiling outcome.
  always_comb begin
    vel_ext  = {{4{vel[11]}}, vel};
    vel_grav = vel_ext + GRAV_S;
    vel_n    = flap_pending ? -FLAP_S : ((vel_grav > MAXF_S) ? MAXF_S : vel_grav);
    pos_n    = $signed({2'b00, pos}) + vel_n;
    hit_floor = (pos_n >= FLOOR_S);
    hit_ceil  = pos_n[15];
    do_play   = (state == ST_PLAYING) || ((state == ST_READY) && flap_pending);
  end

  // Game state machine: advances only on frame ticks so outputs hold steady all frame.
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state     <= ST_READY;
      game_over <= 1'b0;
      pos       <= START_FP;
      vel       <= '0;
      score     <= '0;
      frame_cnt <= '0;
      hold_cnt  <= '0;
    end else if (state == ST_BAD) begin
      state     <= ST_READY;
      game_over <= 1'b0;
      pos       <= START_FP;
      vel       <= '0;
      score     <= '0;
      frame_cnt <= '0;
      hold_cnt  <= '0;
    end else if (bus.iFrameTick) begin
      if (do_play) begin
        if (hit_floor) begin
          // Death freezes the frame counter, so a coincident score step is dropped.
          state     <= ST_DEAD;
          game_over <= 1'b1;
          pos       <= FLOOR_FP;
          vel       <= '0;
          hold_cnt  <= '0;
        end else if (hit_ceil && CEIL_KILL) begin
          state     <= ST_DEAD;
          game_over <= 1'b1;
          pos       <= '0;
          vel       <= '0;
          hold_cnt  <= '0;
        end else begin
          state     <= ST_PLAYING;
          game_over <= 1'b0;
          if (hit_ceil) begin
            pos <= '0;
            vel <= '0;
          end else begin
            pos <= pos_n[13:0];
            vel <= vel_n[11:0];
          end
          if (frame_cnt == SCORE_LAST) begin
            frame_cnt <= '0;
            if (score != 16'hFFFF) begin
              score <= score + 16'd1;
            end
          end else begin
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
      end else if (state == ST_DEAD) begin
        if (hold_cnt == HOLD_DONE) begin
          if (flap_pending) begin
            state     <= ST_READY;
            game_over <= 1'b0;
            pos       <= START_FP;
            vel       <= '0;
            score     <= '0;
            frame_cnt <= '0;
            hold_cnt  <= '0;
          end
        end else begin
          hold_cnt <= hold_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.oBirdY    = pos[13:4];
  assign bus.oScore    = score;
  assign bus.oState    = state;
  assign bus.oGameOver = game_over;

endmodule

// File: tb/tb_bird_physics_controller.sv
// tb/tb_bird_physics_controller.sv - directed and randomized frame-level bench for bird_physics_controller
module tb_bird_physics_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  bird_physics_controller_if bus();

  bird_physics_controller dut (
    .iClock  (clk),
    .iResetN (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam int FLOOR_FP = (480 - 24) * 16;
  localparam int START_FP = 228 * 16;

  // Frame-level reference: game state, fixed-point position/velocity, surviving PLAYING frames, DEAD frames.
  int m_state, m_pos, m_vel, m_alive, m_dead;
  bit m_carry;

  function automatic int m_score();
    int s;
    s = m_alive / 60;
    return (s > 65535) ? 65535 : s;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pos   = START_FP;
    m_vel   = 0;
    m_alive = 0;
    m_dead  = 0;
    m_carry = 1'b0;
  endtask

  task automatic model_tick(input bit flap);
    int v, p;
    bit play;
    play = (m_state == 1) || (m_state == 0 && flap);
    if (play) begin
      if (flap) v = -96;
      else v = (m_vel + 4 > 128) ? 128 : m_vel + 4;
      p = m_pos + v;
      if (p >= FLOOR_FP) begin
        m_pos = FLOOR_FP; m_vel = 0; m_state = 2; m_dead = 0;
      end else if (p < 0) begin
        m_pos = 0; m_vel = 0;
`ifdef BIRD_CEILING_KILL_EN
        m_state = 2; m_dead = 0;
`else
        m_state = 1; m_alive++;
`endif
      end else begin
        m_pos = p; m_vel = v; m_state = 1; m_alive++;
      end
    end else if (m_state == 2) begin
      if (m_dead >= 30 && flap) model_reset();
      else m_dead++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".y"},     32'(bus.oBirdY),    32'(m_pos / 16));
    chk({tag, ".score"}, 32'(bus.oScore),    32'(m_score()));
    chk({tag, ".state"}, 32'(bus.oState),    32'(m_state));
    chk({tag, ".over"},  32'(bus.oGameOver), 32'(m_state == 2));
  endtask

  // One frame: optional one-cycle button press, idle gap, then a tick; checks before and after the tick.
  task automatic do_frame(input bit press, input int gap);
    bit f;
    if (press) bus.iFlap = 1'b1;
    @(negedge clk);
    bus.iFlap = 1'b0;
    repeat (gap - 1) @(negedge clk);
    check_model("stable");
    bus.iFrameTick = 1'b1;
    @(negedge clk);
    bus.iFrameTick = 1'b0;
    f = press | m_carry;
    m_carry = 1'b0;
    model_tick(f);
    check_model("tick");
  endtask

  // Press so the detected edge coincides with the tick cycle: that flap belongs to the next frame.
  task automatic edge_on_tick();
    bus.iFlap = 1'b1;
    @(negedge clk);
    bus.iFlap = 1'b0;
    @(negedge clk);
    bus.iFrameTick = 1'b1;
    @(negedge clk);
    bus.iFrameTick = 1'b0;
    model_tick(1'b0);
    m_carry = 1'b1;
    check_model("edge_on_tick");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.y",     32'(bus.oBirdY),    32'd228);
    chk("rst.score", 32'(bus.oScore),    32'd0);
    chk("rst.state", 32'(bus.oState),    32'd0);
    chk("rst.over",  32'(bus.oGameOver), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic recover();
    repeat (30) do_frame(1'b0, 4);
    do_frame(1'b1, 4);
  endtask

  initial begin
    #3_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    bus.iFlap = 1'b0;
    bus.iFrameTick = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("init.y",     32'(bus.oBirdY),    32'd228);
    chk("init.score", 32'(bus.oScore),    32'd0);
    chk("init.state", 32'(bus.oState),    32'd0);
    chk("init.over",  32'(bus.oGameOver), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    repeat (10) do_frame(1'b0, 4);
    chk("idle.y", 32'(bus.oBirdY), 32'd228);

    edge_on_tick();
    chk("carry.state_ready", 32'(bus.oState), 32'd0);
    do_frame(1'b0, 5);
    chk("first_flap.state", 32'(bus.oState), 32'd1);
    chk("first_flap.y",     32'(bus.oBirdY), 32'd222);
    do_frame(1'b0, 5);
    chk("second_tick.y",    32'(bus.oBirdY), 32'd216);

    for (int i = 0; i < 200 && m_state != 2; i++) do_frame(1'b0, 4);
    chk("floor.y",     32'(bus.oBirdY),    32'd456);
    chk("floor.state", 32'(bus.oState),    32'd2);
    chk("floor.over",  32'(bus.oGameOver), 32'd1);

    repeat (10) do_frame(1'b0, 4);
    do_frame(1'b1, 4);
    chk("hold10.state", 32'(bus.oState), 32'd2);
    repeat (18) do_frame(1'b0, 4);
    do_frame(1'b1, 4);
    chk("hold29.state", 32'(bus.oState), 32'd2);
    do_frame(1'b1, 4);
    chk("restart.state", 32'(bus.oState), 32'd0);
    chk("restart.score", 32'(bus.oScore), 32'd0);
    chk("restart.y",     32'(bus.oBirdY), 32'd228);

    for (int t = 0; t < 180; t++) begin
      do_frame(t == 0 || t == 49 || t == 98 || t == 99 || t == 100, 4);
      if (t == 119) chk("score120", 32'(bus.oScore), 32'd2);
    end
    chk("death_on_inc.score", 32'(bus.oScore), 32'd2);
    chk("death_on_inc.state", 32'(bus.oState), 32'd2);

    recover();
    chk("recover.state", 32'(bus.oState), 32'd0);
    for (int t = 0; t < 38; t++) do_frame(1'b1, 4);
    chk("ceil_top.y",     32'(bus.oBirdY), 32'd0);
    chk("ceil_top.state", 32'(bus.oState), 32'd1);
    do_frame(1'b1, 4);
    chk("ceil_under.y", 32'(bus.oBirdY), 32'd0);
`ifdef BIRD_CEILING_KILL_EN
    chk("ceil_under.state", 32'(bus.oState), 32'd2);
`else
    chk("ceil_under.state", 32'(bus.oState), 32'd1);
`endif
    repeat (3) do_frame(1'b1, 4);

    do_reset();
    do_frame(1'b1, 4);
    repeat (5) do_frame(1'b0, 4);
    chk("pre_reset.state", 32'(bus.oState), 32'd1);
    do_reset();
    repeat (10) do_frame(1'b0, 4);
    chk("post_reset.state", 32'(bus.oState), 32'd0);

    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      do_frame($urandom_range(0, 8) == 0, 4 + int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
